// File: rtl/lcd_pkg.sv
// Shared constants for the Wishbone LCD command sequencer.
// Holds the register map, init command list, state encoding and bus request payload.
package lcd_pkg;

  localparam logic [31:0] ADDR_GO     = 32'h0000_0000;
  localparam logic [31:0] ADDR_DATA   = 32'h0000_0004;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0008;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned INIT_LEN        = 4;
  localparam int unsigned STATE_W         = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WDAT  = 3'd2;
  localparam logic [2:0] S_GO1   = 3'd3;
  localparam logic [2:0] S_GO0   = 3'd4;
  localparam logic [2:0] S_POLL  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  typedef struct packed {
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  // Power-up command list: 8-bit 2-line, display on, entry mode, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = 8'h38;
      2'd1:    c = 8'h0C;
      2'd2:    c = 8'h06;
      default: c = 8'h01;
    endcase
    return c;
  endfunction

  // Bus request presented on entry to each transaction state; idle otherwise.
  function automatic wb_req_t wb_launch(input logic [2:0] st, input logic [7:0] cmd);
    wb_req_t r;
    r = '0;
    case (st)
      S_WDAT: begin
        r.stb = 1'b1; r.we = 1'b1; r.adr = ADDR_DATA; r.dat = {24'h0, cmd};
      end
      S_GO1: begin
        r.stb = 1'b1; r.we = 1'b1; r.adr = ADDR_GO; r.dat = 32'h1;
      end
      S_GO0: begin
        r.stb = 1'b1; r.we = 1'b1; r.adr = ADDR_GO; r.dat = 32'h0;
      end
      S_POLL: begin
        r.stb = 1'b1; r.we = 1'b0; r.adr = ADDR_STATUS; r.dat = 32'h0;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_lcd_seq_if.sv
// Wishbone master port bundle between the LCD sequencer and the wb_fuente slave.
interface wb_lcd_seq_if;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous host command FIFO; extra pointer bit separates full from empty.
// ready_o is registered so it is low in reset and rises the cycle after release.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             empty_nxt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             ready_q;
  logic             push_ok;
  logic             pop_ok;
  logic             full_nxt;

  assign push_ok = push_i & ready_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign ready_o = ready_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  assign full_nxt    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  assign empty_nxt_o = (wr_ptr_d == rd_ptr_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ~full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/wb_lcd_seq.sv
// Wishbone master that replays the LCD init list, then drains host commands as
// DATA write, GO pulse (1 then 0) and STATUS polling, with a one-cycle gap between cycles.
module wb_lcd_seq
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POLL_MAX   = 255,
  parameter int unsigned ACK_MAX    = 15
) (
  input  logic          clk,
  input  logic          rst,
  wb_lcd_seq_if.master  wb,
  input  logic          cmd_valid,
  input  logic [7:0]    cmd_data,
  output logic          cmd_ready,
  output logic          init_done,
  output logic          busy,
  output logic          timeout_err
);

  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
  localparam int unsigned ACK_W  = $clog2(ACK_MAX + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] ret_q, ret_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [2:0]         init_idx_q, init_idx_d;
  logic               is_init_q, is_init_d;
  logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
  wb_req_t            req_q, req_d;
  logic               init_done_q, init_done_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;

  logic               fifo_pop;
  logic [7:0]         fifo_rdata;
  logic               fifo_empty;
  logic               fifo_empty_nxt;
  logic               init_pending;
  logic               status_busy;
  logic               cmd_end;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cmd_valid),
    .data_i      (cmd_data),
    .ready_o     (cmd_ready),
    .pop_i       (fifo_pop),
    .data_o      (fifo_rdata),
    .empty_o     (fifo_empty),
    .empty_nxt_o (fifo_empty_nxt)
  );

  assign init_pending = (init_idx_q < 3'(INIT_LEN));
  assign status_busy  = |(wb.wbm_dat_i & (32'h1 << STATUS_BUSY_BIT));

  // Next-state and bus request logic; bus outputs are registered from req_d.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cmd_d       = cmd_q;
    init_idx_d  = init_idx_q;
    is_init_d   = is_init_q;
    poll_cnt_d  = poll_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    req_d       = req_q;
    init_done_d = init_done_q;
    timeout_d   = timeout_q;
    fifo_pop    = 1'b0;
    cmd_end     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_pending || !fifo_empty) state_d = S_FETCH;
      end

      S_FETCH: begin
        poll_cnt_d = '0;
        ack_cnt_d  = '0;
        if (init_pending) begin
          cmd_d      = init_cmd(init_idx_q[1:0]);
          init_idx_d = init_idx_q + 3'd1;
          is_init_d  = 1'b1;
          req_d      = wb_launch(S_WDAT, cmd_d);
          state_d    = S_WDAT;
        end else if (!fifo_empty) begin
          cmd_d     = fifo_rdata;
          fifo_pop  = 1'b1;
          is_init_d = 1'b0;
          req_d     = wb_launch(S_WDAT, cmd_d);
          state_d   = S_WDAT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WDAT, S_GO1, S_GO0, S_POLL: begin
        if (wb.wbm_ack_i) begin
          req_d     = '0;
          ack_cnt_d = '0;
          state_d   = S_GAP;
          case (state_q)
            S_WDAT: ret_d = S_GO1;
            S_GO1:  ret_d = S_GO0;
            S_GO0:  ret_d = S_POLL;
            default: begin
              poll_cnt_d = poll_cnt_q + POLL_W'(1);
              if (!status_busy) begin
                ret_d   = S_IDLE;
                cmd_end = 1'b1;
              end else if (poll_cnt_d == POLL_W'(POLL_MAX)) begin
                ret_d     = S_IDLE;
                timeout_d = 1'b1;
                cmd_end   = 1'b1;
              end else begin
                ret_d = S_POLL;
              end
            end
          endcase
        end else if (ack_cnt_q == ACK_W'(ACK_MAX - 1)) begin
          // Slave never answered: abandon this command and move on.
          req_d     = '0;
          ack_cnt_d = '0;
          timeout_d = 1'b1;
          cmd_end   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      S_GAP: begin
        state_d = ret_q;
        req_d   = wb_launch(ret_q, cmd_q);
      end

      default: begin
        state_d = S_IDLE;
        req_d   = '0;
      end
    endcase

    if (cmd_end && is_init_q && (init_idx_q == 3'(INIT_LEN))) init_done_d = 1'b1;
  end

  assign busy_d = (state_d != S_IDLE) || !fifo_empty_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      cmd_q       <= '0;
      init_idx_q  <= '0;
      is_init_q   <= 1'b0;
      poll_cnt_q  <= '0;
      ack_cnt_q   <= '0;
      req_q       <= '0;
      init_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cmd_q       <= cmd_d;
      init_idx_q  <= init_idx_d;
      is_init_q   <= is_init_d;
      poll_cnt_q  <= poll_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      req_q       <= req_d;
      init_done_q <= init_done_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign wb.wbm_stb_o = req_q.stb;
  assign wb.wbm_cyc_o = req_q.stb;
  assign wb.wbm_we_o  = req_q.we;
  assign wb.wbm_adr_o = req_q.adr;
  assign wb.wbm_sel_o = {4{req_q.stb}};
  assign wb.wbm_dat_o = req_q.dat;

  assign init_done   = init_done_q;
  assign timeout_err = timeout_q;
  assign busy        = busy_q;

endmodule
